// File: rtl/vga_layer_compositor_pkg.sv
// Shared constants and types for the VGA output compositor.
// VGA_CH_W(cw) gives the width of one colour channel of a packed {r,g,b} pixel.
`ifndef VGA_CH_W
`define VGA_CH_W(cw) ((cw) / 3)
`endif

package vga_layer_compositor_pkg;

  localparam int          COLOR_W_DEF = 12;
  localparam int          VGA_OUT_LAT = 2;   // input-to-pad latency, used upstream for alignment
  localparam logic [11:0] RGB_BLACK   = 12'h000;

  // Fade-out sequencer states (only used when VGA_OUT_FADE_EN is defined).
  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_RUN  = 2'd1,
    FADE_DONE = 2'd2
  } fade_state_e;

endpackage

// File: rtl/vga_layer_compositor_if.sv
// Pixel bus into and out of the compositor: aligned sync/blank/layer data in,
// registered sync and colour channels out.
interface vga_layer_compositor_if #(
  parameter int N_LAYERS = 5,
  parameter int COLOR_W  = 12
);

  logic                          hsync_in;
  logic                          vsync_in;
  logic                          hblnk_in;
  logic                          vblnk_in;
  logic [N_LAYERS*COLOR_W-1:0]   layer_rgb;
  logic [N_LAYERS-1:0]           layer_opq;
  logic                          hs;
  logic                          vs;
  logic [COLOR_W/3-1:0]          r;
  logic [COLOR_W/3-1:0]          g;
  logic [COLOR_W/3-1:0]          b;

  // Upstream draw pipeline side.
  modport master (
    output hsync_in, vsync_in, hblnk_in, vblnk_in, layer_rgb, layer_opq,
    input  hs, vs, r, g, b
  );

  // Compositor side.
  modport slave (
    input  hsync_in, vsync_in, hblnk_in, vblnk_in, layer_rgb, layer_opq,
    output hs, vs, r, g, b
  );

endinterface

// File: rtl/vga_layer_compositor_layer_prio_sel.sv
// Combinational layer selector: the highest-index layer that is both enabled
// and opaque wins; hit is low when no layer qualifies.
module vga_layer_compositor_layer_prio_sel #(
  parameter int N_LAYERS = 5,
  parameter int COLOR_W  = 12
) (
  input  logic [N_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]         layer_opq,
  input  logic [N_LAYERS-1:0]         layer_en,
  output logic [COLOR_W-1:0]          win_rgb,
  output logic                        hit
);

  // Ascending scan so later (higher) qualifying layers overwrite lower ones.
  always_comb begin
    win_rgb = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (layer_en[i] && layer_opq[i]) begin
        win_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Final VGA output stage: merges N_LAYERS pixel streams by fixed priority and
// per-pixel opacity, applies blanking, and registers hs/vs/r/g/b with a fixed
// two-clock latency. Layer enables only change on the vsync rising edge.
// Optional fade-out to black is built when VGA_OUT_FADE_EN is defined.
module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int N_LAYERS = 5,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int FCNT_W   = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  vga_layer_compositor_if.slave vif,
  input  logic [N_LAYERS-1:0]   layer_en_req,
  input  logic                  fade_start,
  output logic [N_LAYERS-1:0]   layer_en,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  fade_done
);

  localparam int CH_W = `VGA_CH_W(COLOR_W);

  logic                        hs_p1_d,  hs_p1_q;
  logic                        vs_p1_d,  vs_p1_q;
  logic                        hb_p1_d,  hb_p1_q;
  logic                        vb_p1_d,  vb_p1_q;
  logic [N_LAYERS*COLOR_W-1:0] rgb_p1_d, rgb_p1_q;
  logic [N_LAYERS-1:0]         opq_p1_d, opq_p1_q;

  logic                        hs_p2_d,  hs_p2_q;
  logic                        vs_p2_d,  vs_p2_q;
  logic [COLOR_W-1:0]          rgb_p2_d, rgb_p2_q;

  logic [N_LAYERS-1:0]         layer_en_d, layer_en_q;
  logic [FCNT_W-1:0]           frame_cnt_d, frame_cnt_q;

  logic                        fb;
  logic [COLOR_W-1:0]          win_rgb;
  logic                        win_hit;

`ifdef VGA_OUT_FADE_EN
  fade_state_e                 fade_state_d, fade_state_q;
  logic [3:0]                  bri_d, bri_q;

  // Brightness scaling: (ch * (bri + 1)) >> 4, identity at bri = 15.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                               input logic [3:0]      bri);
    logic [4:0]      bri_p1;
    logic [CH_W+4:0] prod;
    bri_p1   = {1'b0, bri} + 5'd1;
    prod     = {5'b0, ch} * {{CH_W{1'b0}}, bri_p1};
    scale_ch = CH_W'(prod >> 4);
  endfunction
`endif

  // ---- stage 1: capture inputs ----
  // Stage-1 next values are the raw inputs; vs_p1_q doubles as vsync_d.
  always_comb begin
    hs_p1_d  = vif.hsync_in;
    vs_p1_d  = vif.vsync_in;
    hb_p1_d  = vif.hblnk_in;
    vb_p1_d  = vif.vblnk_in;
    rgb_p1_d = vif.layer_rgb;
    opq_p1_d = vif.layer_opq;
  end

  // Stage-1 pipeline registers, cleared by reset so the output starts black.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      hb_p1_q  <= 1'b0;
      vb_p1_q  <= 1'b0;
      rgb_p1_q <= '0;
      opq_p1_q <= '0;
    end else begin
      hs_p1_q  <= hs_p1_d;
      vs_p1_q  <= vs_p1_d;
      hb_p1_q  <= hb_p1_d;
      vb_p1_q  <= vb_p1_d;
      rgb_p1_q <= rgb_p1_d;
      opq_p1_q <= opq_p1_d;
    end
  end

  // Frame boundary on vsync rising edge; after reset vsync_d is 0, so a
  // vsync already high at release counts as a boundary.
  assign fb = vif.vsync_in & ~vs_p1_q;

  // Enables and frame counter only move at the frame boundary.
  always_comb begin
    layer_en_d  = layer_en_q;
    frame_cnt_d = frame_cnt_q;
    if (fb) begin
      layer_en_d  = layer_en_req;
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end
  end

  // Frame-synchronous control registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      layer_en_q  <= '1;
      frame_cnt_q <= '0;
    end else begin
      layer_en_q  <= layer_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_OUT_FADE_EN
  // Fade sequencer: start only from full brightness, step down once per frame.
  always_comb begin
    fade_state_d = fade_state_q;
    bri_d        = bri_q;
    unique case (fade_state_q)
      FADE_IDLE: begin
        if (fade_start && (bri_q == 4'hF)) begin
          fade_state_d = FADE_RUN;
        end
      end
      FADE_RUN: begin
        if (fb) begin
          bri_d = bri_q - 4'd1;
          if (bri_q == 4'd1) begin
            fade_state_d = FADE_DONE;
          end
        end
      end
      FADE_DONE: begin
        fade_state_d = FADE_DONE;
      end
      default: begin
        fade_state_d = FADE_IDLE;
      end
    endcase
  end

  // Fade state and brightness registers; done is held until reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      fade_state_q <= FADE_IDLE;
      bri_q        <= 4'hF;
    end else begin
      fade_state_q <= fade_state_d;
      bri_q        <= bri_d;
    end
  end

  assign fade_done = (fade_state_q == FADE_DONE);
`else
  logic unused_fade_start;
  assign unused_fade_start = fade_start;
  assign fade_done         = 1'b0;
`endif

  vga_layer_compositor_layer_prio_sel #(
    .N_LAYERS (N_LAYERS),
    .COLOR_W  (COLOR_W)
  ) u_prio_sel (
    .layer_rgb (rgb_p1_q),
    .layer_opq (opq_p1_q),
    .layer_en  (layer_en_q),
    .win_rgb   (win_rgb),
    .hit       (win_hit)
  );

  // ---- stage 2: select, blank, scale ----
  // Blanking or no qualifying layer forces black; syncs follow the pixel.
  always_comb begin
    rgb_p2_d = '0;
    hs_p2_d  = hs_p1_q;
    vs_p2_d  = vs_p1_q;
    if (!(hb_p1_q || vb_p1_q) && win_hit) begin
`ifdef VGA_OUT_FADE_EN
      rgb_p2_d = {scale_ch(win_rgb[2*CH_W +: CH_W], bri_q),
                  scale_ch(win_rgb[1*CH_W +: CH_W], bri_q),
                  scale_ch(win_rgb[0*CH_W +: CH_W], bri_q)};
`else
      rgb_p2_d = win_rgb;
`endif
    end
  end

  // Stage-2 output registers driving the pads.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
      rgb_p2_q <= '0;
    end else begin
      hs_p2_q  <= hs_p2_d;
      vs_p2_q  <= vs_p2_d;
      rgb_p2_q <= rgb_p2_d;
    end
  end

  assign vif.hs    = hs_p2_q;
  assign vif.vs    = vs_p2_q;
  assign vif.r     = rgb_p2_q[2*CH_W +: CH_W];
  assign vif.g     = rgb_p2_q[1*CH_W +: CH_W];
  assign vif.b     = rgb_p2_q[0*CH_W +: CH_W];
  assign layer_en  = layer_en_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Testbench for vga_layer_compositor: reference model + scoreboard queue.
// Build with +define+VGA_OUT_FADE_EN to include the fade scenario.
module tb_vga_layer_compositor;
  import vga_layer_compositor_pkg::*;

  localparam int N  = 5;
  localparam int CW = 12;
  localparam int FW = 8;
  localparam int CH = CW / 3;

  logic          pclk = 1'b0;
  logic          rst;
  logic [N-1:0]  layer_en_req;
  logic          fade_start;
  logic [N-1:0]  layer_en;
  logic [FW-1:0] frame_cnt;
  logic          fade_done;

  vga_layer_compositor_if #(.N_LAYERS(N), .COLOR_W(CW)) vif ();

  vga_layer_compositor #(.N_LAYERS(N), .COLOR_W(CW), .FCNT_W(FW)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vif          (vif),
    .layer_en_req (layer_en_req),
    .fade_start   (fade_start),
    .layer_en     (layer_en),
    .frame_cnt    (frame_cnt),
    .fade_done    (fade_done)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  logic [CW+1:0] sb[$];

  logic [N-1:0]  m_en;
  logic          m_vsd;
  logic [FW-1:0] m_fcnt;
  logic [3:0]    m_bri;
  logic          m_act;
  logic          m_done;

  logic [N*CW-1:0] pix_a;

  function automatic logic [CW-1:0] model_rgb(input logic [N*CW-1:0] rgb,
                                              input logic [N-1:0] opq,
                                              input logic [N-1:0] en,
                                              input logic blank,
                                              input logic [3:0] bri);
    logic [CW-1:0] px;
    logic          found;
    int            v;
    px = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && en[i] && opq[i]) begin
        px = rgb[i*CW +: CW];
        found = 1'b1;
      end
    end
    if (blank || !found) return '0;
    for (int c = 0; c < 3; c++) begin
      v = (int'(px[c*CH +: CH]) * (int'(bri) + 1)) / 16;
      px[c*CH +: CH] = CH'(v);
    end
    return px;
  endfunction

  task automatic model_reset();
    m_en   = '1;
    m_vsd  = 1'b0;
    m_fcnt = '0;
    m_bri  = 4'hF;
    m_act  = 1'b0;
    m_done = 1'b0;
    sb.delete();
  endtask

  // Drive one pixel, update the model, queue the expected output, advance a clock.
  task automatic drive(input logic hsi, input logic vsi, input logic hb, input logic vb,
                       input logic [N*CW-1:0] rgb, input logic [N-1:0] opq,
                       input logic [N-1:0] enr, input logic fs);
    logic fbm;
    vif.hsync_in  = hsi;
    vif.vsync_in  = vsi;
    vif.hblnk_in  = hb;
    vif.vblnk_in  = vb;
    vif.layer_rgb = rgb;
    vif.layer_opq = opq;
    layer_en_req  = enr;
    fade_start    = fs;
    fbm   = vsi & ~m_vsd;
    m_vsd = vsi;
    if (fbm) begin
      m_en = enr;
      m_fcnt++;
      if (m_act) begin
        m_bri--;
        if (m_bri == 4'd0) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
`ifdef VGA_OUT_FADE_EN
    if (fs && m_bri == 4'hF && !m_act && !m_done) m_act = 1'b1;
`endif
    sb.push_back({hsi, vsi, model_rgb(rgb, opq, m_en, hb | vb, m_bri)});
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset(input logic [N-1:0] enr);
    rst = 1'b1;
    layer_en_req = enr;
    fade_start = 1'b0;
    @(posedge pclk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.hblnk_in = 1'b0; vif.vblnk_in = 1'b0;
    vif.layer_rgb = '1; vif.layer_opq = '1;
    apply_reset('0);
    checks++; if (vif.hs !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b want 0", vif.hs); end
    checks++; if (vif.vs !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b want 0", vif.vs); end
    checks++; if ({vif.r, vif.g, vif.b} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {vif.r, vif.g, vif.b}); end
    checks++; if (layer_en !== 5'b11111) begin errors++; $display("FAIL reset_en: got %b want 11111", layer_en); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_fcnt: got %h want 0", frame_cnt); end
    checks++; if (fade_done !== 1'b0) begin errors++; $display("FAIL reset_fade_done: got %b want 0", fade_done); end
  endtask

  task automatic test_priority();
    logic [CW+1:0] e;
    for (int i = 0; i < 10; i++) begin
      drive((i % 3) == 0, (i % 4) == 1, 1'b0, 1'b0, pix_a, 5'b01001, 5'b11111, 1'b0);
      if (sb.size() >= 2) begin
        e = sb.pop_front(); checks++;
        if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
          errors++; $display("FAIL prio: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
        end
      end
    end
    checks++;
    if ({vif.r, vif.g, vif.b} !== 12'hF00) begin errors++; $display("FAIL prio_top: got %h want F00", {vif.r, vif.g, vif.b}); end
  endtask

  task automatic test_blank();
    logic [CW+1:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, i < 4, (i == 5) || (i == 6), pix_a, 5'b01001, 5'b11111, 1'b0);
      if (sb.size() >= 2) begin
        e = sb.pop_front(); checks++;
        if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
          errors++; $display("FAIL blank: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
        end
      end
      if (i == 4) begin
        checks++;
        if ({vif.r, vif.g, vif.b} !== 12'h000) begin errors++; $display("FAIL blank_black: got %h want 000", {vif.r, vif.g, vif.b}); end
      end
    end
  endtask

  task automatic test_random();
    logic [CW+1:0]   e;
    logic [N*CW-1:0] px;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++) px[k*CW +: CW] = CW'($urandom());
      drive(1'($urandom()), 1'($urandom()), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            px, N'($urandom()), N'($urandom()), 1'b0);
      if (sb.size() >= 2) begin
        e = sb.pop_front(); checks++;
        if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
          errors++; $display("FAIL rand: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
        end
      end
      checks++;
      if (layer_en !== m_en || frame_cnt !== m_fcnt) begin
        errors++; $display("FAIL rand_ctrl: got en=%b fc=%h want en=%b fc=%h", layer_en, frame_cnt, m_en, m_fcnt);
      end
    end
  endtask

  task automatic test_enable_switch();
    logic [CW+1:0] e;
    logic [FW-1:0] fc0;
    logic [N-1:0]  enr;
    logic          vsi;
    for (int i = 0; i < 24; i++) begin
      vsi = (i == 1) || (i == 12) || (i == 18);
      enr = (i < 5) ? 5'b11111 : (i < 17) ? 5'b00001 : 5'b01000;
      if (i == 5) fc0 = m_fcnt;
      drive(1'b0, vsi, 1'b0, 1'b0, pix_a, 5'b01001, enr, 1'b0);
      if (sb.size() >= 2) begin
        e = sb.pop_front(); checks++;
        if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
          errors++; $display("FAIL en_switch: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
        end
      end
      if (i == 10) begin
        checks++;
        if (layer_en !== 5'b11111) begin errors++; $display("FAIL en_midframe: got %b want 11111", layer_en); end
        checks++;
        if ({vif.r, vif.g, vif.b} !== 12'hF00) begin errors++; $display("FAIL en_midframe_rgb: got %h want F00", {vif.r, vif.g, vif.b}); end
      end
      if (i == 15) begin
        checks++;
        if (layer_en !== 5'b00001) begin errors++; $display("FAIL en_applied: got %b want 00001", layer_en); end
        checks++;
        if (frame_cnt !== fc0 + 8'd1) begin errors++; $display("FAIL en_fcnt: got %h want %h", frame_cnt, fc0 + 8'd1); end
        checks++;
        if ({vif.r, vif.g, vif.b} !== 12'h00F) begin errors++; $display("FAIL en_applied_rgb: got %h want 00F", {vif.r, vif.g, vif.b}); end
      end
    end
    checks++;
    if (layer_en !== 5'b01000) begin errors++; $display("FAIL en_same_cycle: got %b want 01000", layer_en); end
  endtask

  task automatic test_frame_wrap();
    logic [CW+1:0] e;
    int            guard;
    guard = 0;
    while (m_fcnt != 8'hFF && guard < 300) begin
      guard++;
      for (int p = 0; p < 2; p++) begin
        drive(1'b0, p == 0, 1'b0, 1'b0, pix_a, 5'b01001, 5'b11111, 1'b0);
        if (sb.size() >= 2) begin
          e = sb.pop_front(); checks++;
          if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
            errors++; $display("FAIL wrap_px: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
          end
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_max: got %h want FF", frame_cnt); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, pix_a, 5'b01001, 5'b11111, 1'b0);
    checks++;
    if (frame_cnt !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %h want 00", frame_cnt); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, pix_a, 5'b01001, 5'b11111, 1'b0);
  endtask

  task automatic test_reset_midline();
    logic [CW+1:0] e;
    drive(1'b1, 1'b0, 1'b0, 1'b0, pix_a, 5'b01001, 5'b00000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, pix_a, 5'b01001, 5'b00000, 1'b0);
    apply_reset(5'b00000);
    checks++; if ({vif.r, vif.g, vif.b} !== 12'h000) begin errors++; $display("FAIL rst_mid_rgb: got %h want 000", {vif.r, vif.g, vif.b}); end
    checks++; if (layer_en !== 5'b11111) begin errors++; $display("FAIL rst_mid_en: got %b want 11111", layer_en); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL rst_mid_fcnt: got %h want 0", frame_cnt); end
    checks++; if (vif.hs !== 1'b0) begin errors++; $display("FAIL rst_mid_hs: got %b want 0", vif.hs); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, i < 3, 1'b0, 1'b0, pix_a, 5'b01001, 5'b00001, 1'b0);
      if (i == 0) begin
        checks++;
        if (layer_en !== 5'b00001 || frame_cnt !== 8'd1) begin
          errors++; $display("FAIL rst_release_fb: got en=%b fc=%h want en=00001 fc=01", layer_en, frame_cnt);
        end
      end
      if (sb.size() >= 2) begin
        e = sb.pop_front(); checks++;
        if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
          errors++; $display("FAIL rst_mid_px: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
        end
      end
    end
  endtask

`ifdef VGA_OUT_FADE_EN
  task automatic test_fade();
    logic [CW+1:0]   e;
    logic [N*CW-1:0] px;
    px = pix_a;
    px[0 +: CW] = 12'hFFF;
    for (int f = 0; f < 16; f++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1'b0, (p == 0) && (f > 0), 1'b0, 1'b0, px, 5'b00001, 5'b11111,
              ((f == 0) && (p == 1)) || ((f == 5) && (p == 2)));
        if (sb.size() >= 2) begin
          e = sb.pop_front(); checks++;
          if ({vif.hs, vif.vs, vif.r, vif.g, vif.b} !== e) begin
            errors++; $display("FAIL fade_px: got %h want %h", {vif.hs, vif.vs, vif.r, vif.g, vif.b}, e);
          end
        end
      end
      if (f == 1) begin
        checks++;
        if ({vif.r, vif.g, vif.b} !== 12'hEEE) begin errors++; $display("FAIL fade_one: got %h want EEE", {vif.r, vif.g, vif.b}); end
        checks++;
        if (fade_done !== 1'b0) begin errors++; $display("FAIL fade_early_done: got %b want 0", fade_done); end
      end
    end
    checks++;
    if ({vif.r, vif.g, vif.b} !== 12'h000) begin errors++; $display("FAIL fade_black: got %h want 000", {vif.r, vif.g, vif.b}); end
    checks++;
    if (fade_done !== 1'b1) begin errors++; $display("FAIL fade_done: got %b want 1", fade_done); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    layer_en_req = '0;
    fade_start = 1'b0;
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b0; vif.hblnk_in = 1'b0; vif.vblnk_in = 1'b0;
    vif.layer_rgb = '0; vif.layer_opq = '0;
    pix_a = '0;
    pix_a[0*CW +: CW] = 12'h00F;
    pix_a[1*CW +: CW] = 12'h0F0;
    pix_a[2*CW +: CW] = 12'h333;
    pix_a[3*CW +: CW] = 12'hF00;
    pix_a[4*CW +: CW] = 12'hABC;
    model_reset();

    test_reset();
    test_priority();
    test_blank();
    test_random();
    test_enable_switch();
    test_frame_wrap();
    test_reset_midline();
`ifdef VGA_OUT_FADE_EN
    test_fade();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
